// File: rtl/morse_round_ctrl.sv
// Single-clock round controller for the morse duel: player 1 records a symbol
// sequence, player 2 replays it, and the replay is scored with a per-symbol timeout.
module morse_round_ctrl #(
  parameter int SYM_W         = 2,
  parameter int DEPTH         = 16,
  parameter int ADDR_W        = 4,
  parameter int TIMEOUT_TICKS = 8,
  parameter int TICK_W        = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              tick,
  input  logic              done_pulse,
  input  logic              p1_valid,
  input  logic [SYM_W-1:0]  p1_sym,
  input  logic              p2_valid,
  input  logic [SYM_W-1:0]  p2_sym,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   p1_count,
  output logic [ADDR_W:0]   p2_index,
  output logic [SYM_W-1:0]  expected_sym,
  output logic              last_correct,
  output logic [ADDR_W:0]   mismatches,
  output logic              overflow,
  output logic              extra,
  output logic              timed_out,
  output logic              pass
);

  // state    | meaning
  // S_START  | idle between rounds, results of the previous round still shown
  // S_P1     | player 1 recording symbols into the store
  // S_P2     | player 2 replaying, each symbol compared and timed
  // S_RESULT | round scored, pass is valid
  typedef enum logic [1:0] {
    S_START  = 2'd0,
    S_P1     = 2'd1,
    S_P2     = 2'd2,
    S_RESULT = 2'd3
  } state_e;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [TICK_W:0] TMO_LIM = (TICK_W+1)'(TIMEOUT_TICKS);
  localparam logic [TICK_W:0] TMO_ONE = (TICK_W+1)'(1);
  localparam bit              TMO_EN  = (TIMEOUT_TICKS != 0);

  state_e             state_q, state_d;
  logic [ADDR_W:0]    p1_count_q, p1_count_d;
  logic [ADDR_W:0]    p2_index_q, p2_index_d;
  logic [ADDR_W:0]    mism_q, mism_d;
  logic               overflow_q, overflow_d;
  logic               extra_q, extra_d;
  logic               timed_out_q, timed_out_d;
  logic               last_correct_q, last_correct_d;
  logic               pass_q, pass_d;
  logic [TICK_W-1:0]  tmo_q, tmo_d;

  // Store is deliberately not reset; p1_count = 0 hides stale contents.
  logic [SYM_W-1:0]   mem_q [DEPTH];
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_idx;
  logic [ADDR_W-1:0]  rd_idx;
  logic [SYM_W-1:0]   stored_sym;
  logic               p2_in_range;
  logic [TICK_W:0]    tmo_inc;

  assign wr_idx      = p1_count_q[ADDR_W-1:0];
  assign rd_idx      = p2_index_q[ADDR_W-1:0];
  assign stored_sym  = mem_q[rd_idx];
  assign p2_in_range = (p2_index_q < p1_count_q);
  assign tmo_inc     = {1'b0, tmo_q} + TMO_ONE;

  always_comb begin
    state_d        = state_q;
    p1_count_d     = p1_count_q;
    p2_index_d     = p2_index_q;
    mism_d         = mism_q;
    overflow_d     = overflow_q;
    extra_d        = extra_q;
    timed_out_d    = timed_out_q;
    last_correct_d = last_correct_q;
    pass_d         = pass_q;
    tmo_d          = tmo_q;
    wr_en          = 1'b0;

    unique case (state_q)
      S_START: begin
        if (done_pulse) begin
          state_d        = S_P1;
          p1_count_d     = '0;
          p2_index_d     = '0;
          mism_d         = '0;
          overflow_d     = 1'b0;
          extra_d        = 1'b0;
          timed_out_d    = 1'b0;
          last_correct_d = 1'b0;
          pass_d         = 1'b0;
        end
      end

      S_P1: begin
        if (p1_valid) begin
          if (p1_count_q < DEPTH_C) begin
            wr_en      = 1'b1;
            p1_count_d = p1_count_q + CNT_ONE;
          end else begin
            overflow_d = 1'b1;
          end
        end
        // A same-cycle symbol counts toward the non-empty check.
        if (done_pulse && (p1_count_d != '0)) begin
          state_d = S_P2;
          tmo_d   = '0;
        end
      end

      S_P2: begin
        if (p2_valid) begin
          if (p2_in_range) begin
            last_correct_d = (p2_sym == stored_sym);
            if (p2_sym != stored_sym) mism_d = mism_q + CNT_ONE;
            p2_index_d = p2_index_q + CNT_ONE;
            tmo_d      = '0;
          end else begin
            extra_d = 1'b1;
          end
        end else if (tick && TMO_EN) begin
          if (tmo_inc == TMO_LIM) begin
            timed_out_d = 1'b1;
            tmo_d       = '0;
          end else begin
            tmo_d = tmo_inc[TICK_W-1:0];
          end
        end
        if (done_pulse || timed_out_d) begin
          state_d = S_RESULT;
          pass_d  = (p2_index_d == p1_count_q) && (mism_d == '0)
                    && !extra_d && !timed_out_d;
        end
      end

      S_RESULT: begin
        if (done_pulse) begin
          state_d = S_START;
          pass_d  = 1'b0;
        end
      end

      default: state_d = S_START;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_START;
      p1_count_q     <= '0;
      p2_index_q     <= '0;
      mism_q         <= '0;
      overflow_q     <= 1'b0;
      extra_q        <= 1'b0;
      timed_out_q    <= 1'b0;
      last_correct_q <= 1'b0;
      pass_q         <= 1'b0;
      tmo_q          <= '0;
    end else begin
      state_q        <= state_d;
      p1_count_q     <= p1_count_d;
      p2_index_q     <= p2_index_d;
      mism_q         <= mism_d;
      overflow_q     <= overflow_d;
      extra_q        <= extra_d;
      timed_out_q    <= timed_out_d;
      last_correct_q <= last_correct_d;
      pass_q         <= pass_d;
      tmo_q          <= tmo_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_idx] <= p1_sym;
  end

  assign state        = state_q;
  assign p1_count     = p1_count_q;
  assign p2_index     = p2_index_q;
  assign expected_sym = p2_in_range ? stored_sym : '0;
  assign last_correct = last_correct_q;
  assign mismatches   = mism_q;
  assign overflow     = overflow_q;
  assign extra        = extra_q;
  assign timed_out    = timed_out_q;
  assign pass         = pass_q;

endmodule

// File: tb/tb_morse_round_ctrl.sv
// Bench for morse_round_ctrl: table of per-cycle vectors checked through a
// scoreboard queue, plus hand sequences for overflow, timeout and reset.
module tb_morse_round_ctrl;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       tick = 1'b0;
  logic       done_pulse = 1'b0;
  logic       p1_valid = 1'b0;
  logic [1:0] p1_sym = 2'd0;
  logic       p2_valid = 1'b0;
  logic [1:0] p2_sym = 2'd0;
  logic [1:0] state;
  logic [4:0] p1_count;
  logic [4:0] p2_index;
  logic [1:0] expected_sym;
  logic       last_correct;
  logic [4:0] mismatches;
  logic       overflow;
  logic       extra;
  logic       timed_out;
  logic       pass;

  int total = 0;
  int bad   = 0;

  morse_round_ctrl dut (
    .clock        (clock),
    .resetn       (resetn),
    .tick         (tick),
    .done_pulse   (done_pulse),
    .p1_valid     (p1_valid),
    .p1_sym       (p1_sym),
    .p2_valid     (p2_valid),
    .p2_sym       (p2_sym),
    .state        (state),
    .p1_count     (p1_count),
    .p2_index     (p2_index),
    .expected_sym (expected_sym),
    .last_correct (last_correct),
    .mismatches   (mismatches),
    .overflow     (overflow),
    .extra        (extra),
    .timed_out    (timed_out),
    .pass         (pass)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic tk, dn, p1v;
    logic [1:0] p1s;
    logic p2v;
    logic [1:0] p2s;
    int st, p1c, p2i, es, lc, mm, ov, ex, to, ps;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   sb_idx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int tk, dn, p1v, p1s, p2v, p2s,
                     input int st, p1c, p2i, es, lc, mm, ov, ex, to, ps);
    vec_t v;
    v.tk = tk[0]; v.dn = dn[0]; v.p1v = p1v[0]; v.p1s = p1s[1:0];
    v.p2v = p2v[0]; v.p2s = p2s[1:0];
    v.st = st; v.p1c = p1c; v.p2i = p2i; v.es = es; v.lc = lc;
    v.mm = mm; v.ov = ov; v.ex = ex; v.to = to; v.ps = ps;
    vecs.push_back(v);
  endtask

  // One clock of stimulus: drive at the falling edge, return 1ns after the rising edge.
  task automatic cyc(input logic tk, dn, p1v, input logic [1:0] p1s,
                     input logic p2v, input logic [1:0] p2s);
    @(negedge clock);
    tick = tk; done_pulse = dn; p1_valid = p1v; p1_sym = p1s;
    p2_valid = p2v; p2_sym = p2s;
    @(posedge clock);
    #1;
    tick = 1'b0; done_pulse = 1'b0; p1_valid = 1'b0; p2_valid = 1'b0;
  endtask

  always @(posedge clock) begin
    if (sb_q.size() > 0) begin
      vec_t e;
      string n;
      #1;
      e = sb_q.pop_front();
      n = $sformatf("tbl%0d", sb_idx);
      chk({n, " state"},        32'(state),        32'(e.st));
      chk({n, " p1_count"},     32'(p1_count),     32'(e.p1c));
      chk({n, " p2_index"},     32'(p2_index),     32'(e.p2i));
      chk({n, " expected_sym"}, 32'(expected_sym), 32'(e.es));
      chk({n, " last_correct"}, 32'(last_correct), 32'(e.lc));
      chk({n, " mismatches"},   32'(mismatches),   32'(e.mm));
      chk({n, " overflow"},     32'(overflow),     32'(e.ov));
      chk({n, " extra"},        32'(extra),        32'(e.ex));
      chk({n, " timed_out"},    32'(timed_out),    32'(e.to));
      chk({n, " pass"},         32'(pass),         32'(e.ps));
      sb_idx++;
    end
  end

  task automatic chk_all_zero(input string n);
    chk({n, " state"},        32'(state),        0);
    chk({n, " p1_count"},     32'(p1_count),     0);
    chk({n, " p2_index"},     32'(p2_index),     0);
    chk({n, " expected_sym"}, 32'(expected_sym), 0);
    chk({n, " last_correct"}, 32'(last_correct), 0);
    chk({n, " mismatches"},   32'(mismatches),   0);
    chk({n, " overflow"},     32'(overflow),     0);
    chk({n, " extra"},        32'(extra),        0);
    chk({n, " timed_out"},    32'(timed_out),    0);
    chk({n, " pass"},         32'(pass),         0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] ov_syms [18];

    //   tk dn p1v p1s p2v p2s | st p1c p2i es lc mm ov ex to ps
    add(0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0,   1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 3, 0, 0,   1, 2, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 0,   1, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,   2, 3, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1,   2, 3, 1, 3, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 3,   2, 3, 2, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1,   2, 3, 3, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,   3, 3, 3, 0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0,   0, 3, 3, 0, 1, 0, 0, 0, 0, 0);
    // round 2: dash,dash against dot,dash
    add(0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0,   1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 3, 0, 0,   1, 2, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,   2, 2, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 3,   2, 2, 1, 3, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 3,   2, 2, 2, 0, 1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,   3, 2, 2, 0, 1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,   0, 2, 2, 0, 1, 1, 0, 0, 0, 0);
    // round 3: short replay
    add(0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0,   1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 3, 0, 0,   1, 2, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,   2, 2, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1,   2, 2, 1, 3, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,   3, 2, 1, 3, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,   0, 2, 1, 3, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 1, 1,   0, 2, 1, 3, 1, 0, 0, 0, 0, 0);
    // empty-P1 done ignored; symbol coincident with done counts
    add(0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 3, 0, 0,   2, 1, 0, 3, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 3,   3, 1, 1, 0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0,   0, 1, 1, 0, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 18; i++) ov_syms[i] = 2'((i * 3 + 1) % 4);

    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk_all_zero("reset");
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      tick = vecs[i].tk; done_pulse = vecs[i].dn;
      p1_valid = vecs[i].p1v; p1_sym = vecs[i].p1s;
      p2_valid = vecs[i].p2v; p2_sym = vecs[i].p2s;
      sb_q.push_back(vecs[i]);
      @(posedge clock);
      #2;
    end
    tick = 1'b0; done_pulse = 1'b0; p1_valid = 1'b0; p2_valid = 1'b0;
    chk("scoreboard drained", 32'(sb_q.size()), 0);

    // Overflow and extra symbol
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, ov_syms[i], 0, 0);
    chk("ovf count16", 32'(p1_count), 16);
    chk("ovf not yet", 32'(overflow), 0);
    cyc(0, 0, 1, ov_syms[16], 0, 0);
    cyc(0, 0, 1, ov_syms[17], 0, 0);
    chk("ovf count held", 32'(p1_count), 16);
    chk("ovf flag", 32'(overflow), 1);
    cyc(0, 1, 0, 0, 0, 0);
    chk("ovf state P2", 32'(state), 2);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf exp_sym%0d", i), 32'(expected_sym), 32'(ov_syms[i]));
      cyc(0, 0, 0, 0, 1, ov_syms[i]);
    end
    chk("ovf p2_index16", 32'(p2_index), 16);
    chk("ovf mism", 32'(mismatches), 0);
    chk("ovf extra pre", 32'(extra), 0);
    chk("ovf exp_sym end", 32'(expected_sym), 0);
    cyc(0, 0, 0, 0, 1, 1);
    chk("extra flag", 32'(extra), 1);
    chk("extra p2_index", 32'(p2_index), 16);
    chk("extra last_correct", 32'(last_correct), 1);
    cyc(0, 1, 0, 0, 0, 0);
    chk("extra state", 32'(state), 3);
    chk("extra pass", 32'(pass), 0);
    cyc(0, 1, 0, 0, 0, 0);

    // Timeout after 8 idle ticks
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 3, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    chk("to p2_index", 32'(p2_index), 1);
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 0, 0);
    chk("to 7 ticks state", 32'(state), 2);
    chk("to 7 ticks flag", 32'(timed_out), 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("to state", 32'(state), 3);
    chk("to flag", 32'(timed_out), 1);
    chk("to pass", 32'(pass), 0);
    cyc(0, 1, 0, 0, 0, 0);

    // Symbol on the 8th tick wins and restarts the count
    cyc(0, 1, 0, 0, 0, 0);
    chk("to2 cleared", 32'(timed_out), 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 3, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 3);
    chk("to2 state", 32'(state), 2);
    chk("to2 flag", 32'(timed_out), 0);
    chk("to2 p2_index", 32'(p2_index), 2);
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 0, 0);
    chk("to2 restart state", 32'(state), 2);
    cyc(1, 0, 0, 0, 0, 0);
    chk("to2 late state", 32'(state), 3);
    chk("to2 late flag", 32'(timed_out), 1);
    cyc(0, 1, 0, 0, 0, 0);

    // Async reset mid-P2
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 3, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 2);
    chk("rst pre p2_index", 32'(p2_index), 2);
    chk("rst pre mism", 32'(mismatches), 1);
    @(negedge clock);
    #2;
    resetn = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clock);
    resetn = 1'b1;
    cyc(0, 1, 0, 0, 0, 0);
    chk("post rst state", 32'(state), 1);
    chk("post rst p1_count", 32'(p1_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
